// File: rtl/filter_pkg.sv
// Shared types and constants for the 3x3 window filter line-buffer front end.
package filter_pkg;

    localparam int unsigned H_ACT_DEF = 640;
    localparam int unsigned V_ACT_DEF = 480;
    localparam int unsigned COORD_W   = 10;
    localparam int unsigned BANK_W    = 2;
    localparam int unsigned BORDER_W  = 4;
    localparam int unsigned NUM_BANKS = 3;

    // Bit positions inside the {right,left,bottom,top} zero-pad mask
    localparam int unsigned BRD_TOP    = 0;
    localparam int unsigned BRD_BOTTOM = 1;
    localparam int unsigned BRD_LEFT   = 2;
    localparam int unsigned BRD_RIGHT  = 3;

    typedef logic [BANK_W-1:0]  bank_t;
    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        LBC_IDLE,
        LBC_FILL,
        LBC_RUN,
        LBC_FLUSH
    } lbc_state_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
    } pix_pos_t;

    function automatic bank_t bank_inc(input bank_t b);
        return (b == BANK_W'(NUM_BANKS - 1)) ? '0 : b + BANK_W'(1);
    endfunction

    function automatic bank_t bank_dec(input bank_t b);
        return (b == '0) ? BANK_W'(NUM_BANKS - 1) : b - BANK_W'(1);
    endfunction

endpackage

// File: rtl/bank_rotator.sv
// Mod-3 write-bank pointer for the three-row line buffer; read banks for the
// rows above and at the window centre trail the write bank.
module bank_rotator
    import filter_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  clr,
    input  logic  adv,
    output bank_t bot_c,
    output bank_t mid_c,
    output bank_t top_c
);

    bank_t ptr;

    // A frame start forces bank 0 for the pixel arriving in the same cycle
    assign bot_c = clr ? '0 : ptr;
    assign mid_c = bank_dec(bot_c);
    assign top_c = bank_dec(mid_c);

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (adv) begin
            ptr <= bank_inc(bot_c);
        end else begin
            ptr <= bot_c;
        end
    end

endmodule

// File: rtl/linebuf_ctrl.sv
// Line-buffer controller for a 3x3 window filter: write strobes, bank rotation,
// window timing and border mask. Build macro LINEBUF_CTRL_SEQ_CHECK_EN adds raster-successor checking.
module linebuf_ctrl
    import filter_pkg::*;
#(
    parameter int unsigned H_ACT = H_ACT_DEF,
    parameter int unsigned V_ACT = V_ACT_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pix_valid,
    input  logic [COORD_W-1:0]  x_pixel,
    input  logic [COORD_W-1:0]  y_pixel,
    output logic                wr_en,
    output logic [BANK_W-1:0]   wr_bank,
    output logic [COORD_W-1:0]  lb_addr,
    output logic [BANK_W-1:0]   rd_top,
    output logic [BANK_W-1:0]   rd_mid,
    output logic [BANK_W-1:0]   rd_bot,
    output logic                win_valid,
    output logic [COORD_W-1:0]  win_x,
    output logic [COORD_W-1:0]  win_y,
    output logic [BORDER_W-1:0] border,
    output logic                frame_done,
    output logic                err
);

    localparam coord_t X_LAST = COORD_W'(H_ACT - 1);
    localparam coord_t Y_LAST = COORD_W'(V_ACT - 1);

    lbc_state_t          state, state_d;
    coord_t              flush_x, flush_x_d;
    logic                wr_en_d;
    coord_t              lb_addr_d;
    logic                pend_v, pend_v_d;
    pix_pos_t            pend, pend_d;
    logic                frame_done_d, err_d;
    logic                bank_clr, bank_adv, write;
    logic                is_origin, is_eol;
    logic [BORDER_W-1:0] border_c;
    bank_t               bot_c, mid_c, top_c;
`ifdef LINEBUF_CTRL_SEQ_CHECK_EN
    pix_pos_t            expect_pos, expect_pos_d;
    logic                seq_ok;
`endif

    bank_rotator u_bank_rotator (
        .clk   (clk),
        .reset (reset),
        .clr   (bank_clr),
        .adv   (bank_adv),
        .bot_c (bot_c),
        .mid_c (mid_c),
        .top_c (top_c)
    );

    assign is_origin = pix_valid && (x_pixel == '0) && (y_pixel == '0);
    assign is_eol    = (x_pixel == X_LAST);
`ifdef LINEBUF_CTRL_SEQ_CHECK_EN
    assign seq_ok    = (x_pixel == expect_pos.x) && (y_pixel == expect_pos.y);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LBC_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state plus the address stage; a frame-start pixel always restarts FILL
    always_comb begin
        state_d      = state;
        flush_x_d    = flush_x;
        wr_en_d      = 1'b0;
        lb_addr_d    = lb_addr;
        pend_v_d     = 1'b0;
        pend_d       = pend;
        frame_done_d = 1'b0;
        err_d        = 1'b0;
        bank_clr     = 1'b0;
        bank_adv     = 1'b0;
        write        = 1'b0;
`ifdef LINEBUF_CTRL_SEQ_CHECK_EN
        expect_pos_d = expect_pos;
`endif
        unique case (state)
            LBC_IDLE: begin
                if (is_origin) begin
                    state_d  = LBC_FILL;
                    bank_clr = 1'b1;
                    write    = 1'b1;
                end
            end
            LBC_FILL, LBC_RUN: begin
                if (pix_valid) begin
                    if (is_origin) begin
                        err_d    = 1'b1;
                        state_d  = LBC_FILL;
                        bank_clr = 1'b1;
                        write    = 1'b1;
                    end
`ifdef LINEBUF_CTRL_SEQ_CHECK_EN
                    else if (!seq_ok) begin
                        err_d   = 1'b1;
                        state_d = LBC_IDLE;
                    end
`endif
                    else begin
                        write = 1'b1;
                        if (state == LBC_RUN) begin
                            pend_v_d = 1'b1;
                            pend_d   = '{x: x_pixel, y: y_pixel - COORD_W'(1)};
                        end
                        if (is_eol) begin
                            bank_adv = 1'b1;
                            if (state == LBC_FILL) begin
                                state_d = LBC_RUN;
                            end else if (y_pixel == Y_LAST) begin
                                state_d   = LBC_FLUSH;
                                flush_x_d = '0;
                            end
                        end
                    end
                end
            end
            LBC_FLUSH: begin
                err_d     = is_origin;
                lb_addr_d = flush_x;
                pend_v_d  = 1'b1;
                pend_d    = '{x: flush_x, y: Y_LAST};
                if (flush_x == X_LAST) begin
                    state_d      = LBC_IDLE;
                    frame_done_d = 1'b1;
                end else begin
                    flush_x_d = flush_x + COORD_W'(1);
                end
            end
            default: state_d = LBC_IDLE;
        endcase
        if (write) begin
            wr_en_d   = 1'b1;
            lb_addr_d = x_pixel;
`ifdef LINEBUF_CTRL_SEQ_CHECK_EN
            expect_pos_d = is_eol ? '{x: '0, y: y_pixel + COORD_W'(1)}
                                  : '{x: x_pixel + COORD_W'(1), y: y_pixel};
`endif
        end
    end

    always_comb begin
        border_c             = '0;
        border_c[BRD_TOP]    = (pend.y == '0);
        border_c[BRD_BOTTOM] = (pend.y == Y_LAST);
        border_c[BRD_LEFT]   = (pend.x == '0);
        border_c[BRD_RIGHT]  = (pend.x == X_LAST);
    end

    // Window outputs lag the address stage by one cycle to meet the buffer read data
    always_ff @(posedge clk) begin
        if (reset) begin
            flush_x    <= '0;
            wr_en      <= 1'b0;
            wr_bank    <= '0;
            lb_addr    <= '0;
            rd_top     <= '0;
            rd_mid     <= '0;
            rd_bot     <= '0;
            pend_v     <= 1'b0;
            pend       <= '0;
            win_valid  <= 1'b0;
            win_x      <= '0;
            win_y      <= '0;
            border     <= '0;
            frame_done <= 1'b0;
            err        <= 1'b0;
`ifdef LINEBUF_CTRL_SEQ_CHECK_EN
            expect_pos <= '0;
`endif
        end else begin
            flush_x    <= flush_x_d;
            wr_en      <= wr_en_d;
            wr_bank    <= bot_c;
            lb_addr    <= lb_addr_d;
            rd_top     <= top_c;
            rd_mid     <= mid_c;
            rd_bot     <= bot_c;
            pend_v     <= pend_v_d;
            pend       <= pend_d;
            win_valid  <= pend_v;
            frame_done <= frame_done_d;
            err        <= err_d;
            if (pend_v) begin
                win_x  <= pend.x;
                win_y  <= pend.y;
                border <= border_c;
            end
`ifdef LINEBUF_CTRL_SEQ_CHECK_EN
            expect_pos <= expect_pos_d;
`endif
        end
    end

endmodule

// File: doc/linebuf_ctrl.md
LINEBUF_CTRL -- requirements
Module: linebuf_ctrl

Interface
REQ-001 SHALL have parameter H_ACT, default 640, active pixels per line.
REQ-002 SHALL have parameter V_ACT, default 480, active lines per frame.
REQ-003 SHALL have port clk  input  1  system/pixel clock, all logic on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port pix_valid  input  1  active pixel present this cycle.
REQ-006 SHALL have port x_pixel  input  10  column of incoming pixel.
REQ-007 SHALL have port y_pixel  input  10  row of incoming pixel.
REQ-008 SHALL have port wr_en  output  1  line-buffer write strobe.
REQ-009 SHALL have port wr_bank  output  2  bank (0..2) written this cycle.
REQ-010 SHALL have port lb_addr  output  10  shared read/write column address.
REQ-011 SHALL have ports rd_top, rd_mid, rd_bot  output  2 each  bank holding window rows above, at and below centre.
REQ-012 SHALL have port win_valid  output  1  window for (win_x, win_y) is valid.
REQ-013 SHALL have ports win_x, win_y  output  10 each  window centre coordinate.
REQ-014 SHALL have port border  output  4  {right,left,bottom,top} zero-pad mask.
REQ-015 SHALL have ports frame_done  output  1  one-cycle pulse; err  output  1  one-cycle sequence-error pulse.

Function
REQ-016 SHALL implement states IDLE, FILL, RUN, FLUSH.
REQ-017 IDLE SHALL ignore pixels except pix_valid with x_pixel=0, y_pixel=0, which is accepted and moves to FILL.
REQ-018 FILL (row 0) SHALL assert wr_en, lb_addr=x_pixel per accepted pixel, win_valid low; at x_pixel=H_ACT-1 go to RUN.
REQ-019 RUN (rows 1..V_ACT-1) SHALL write each accepted pixel and produce window centre (x_pixel, y_pixel-1); at x=H_ACT-1, y=V_ACT-1 go to FLUSH.
REQ-020 FLUSH SHALL run H_ACT internal cycles, wr_en low, lb_addr=0..H_ACT-1, window centre row V_ACT-1, then pulse frame_done and return to IDLE.
REQ-021 wr_bank SHALL start at 0 on frame start and advance mod 3 after every completed written row.
REQ-022 rd_bot SHALL equal wr_bank, rd_mid SHALL equal wr_bank-1 mod 3, rd_top wr_bank-2 mod 3; in FLUSH rd_mid is the last-written bank.
REQ-023 win_valid, win_x, win_y, border SHALL be registered, one cycle after the addressed pixel (aligned with line-buffer synchronous read data).
REQ-024 border SHALL set top when win_y=0, bottom when win_y=V_ACT-1, left when win_x=0, right when win_x=H_ACT-1; corners set two bits.
REQ-025 pix_valid low SHALL hold all counters and state; win_valid low next cycle.
REQ-026 Pixel x=0,y=0 in FILL or RUN SHALL pulse err, reset wr_bank to 0 and restart FILL with that pixel.
REQ-027 pix_valid in FLUSH SHALL be dropped; x=0,y=0 in FLUSH SHALL pulse err and is not captured.

Reset
REQ-028 reset SHALL force IDLE, wr_bank=0, and all outputs 0 on the next clk edge, overriding any simultaneous pixel; reset mid-frame discards the frame without frame_done.

Configuration
REQ-029 With LINEBUF_CTRL_SEQ_CHECK_EN defined, FILL/RUN SHALL pulse err on any accepted pixel whose (x,y) is not the expected successor, and then resynchronise by waiting in IDLE for the next frame start.
REQ-030 Without LINEBUF_CTRL_SEQ_CHECK_EN, successor checking SHALL be absent, incoming coordinates trusted; REQ-026/027 err behaviour remains.

Structure
REQ-031 Package filter_pkg SHALL hold H_ACT/V_ACT defaults, bank_t (2-bit), lbc_state_t enum, border bit index constants.
REQ-032 The mod-3 bank pointer with derived read banks SHALL be sub-module bank_rotator.

Verification
REQ-033 Full 640x480 frame with blanking gaps -> 307200 win_valid, last at (639,479) with border=bottom|right, one frame_done 640 cycles after last pixel.
REQ-034 Row 0 pixels -> wr_en=1, wr_bank=0, win_valid never high; first window (0,0) border=top|left one cycle after pixel (0,1).
REQ-035 Rows 1,2,3 start -> wr_bank 1,2,0; at row 3 rd_top=1, rd_mid=2, rd_bot=0.
REQ-036 Pixel (0,0) injected at (200,100) -> err pulse, wr_bank=0, state FILL, no frame_done.
REQ-037 reset asserted mid-FLUSH -> next cycle all outputs 0, IDLE, no frame_done.
REQ-038 With LINEBUF_CTRL_SEQ_CHECK_EN, pixel (5,10) following (3,10) -> err pulse, IDLE, no win_valid until next (0,0).
